// File: rtl/fsqrt_arbiter_if.sv
// Bundles the fsqrt arbiter's requester, datapath and response signals.
//   req_valid/req_x/req_ready : per-requester issue handshake, operand i in req_x[32i +: 32]
//   sq_x/sq_y                 : operand to / result from the shared fsqrt pipeline
//   resp_valid/resp_y/resp_id : registered one-hot result return
//   busy/issue_cnt            : status
// master: requester/datapath side. slave: the arbiter.
interface fsqrt_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [32*NREQ-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic [31:0]       sq_x;
  logic [31:0]       sq_y;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_y;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [31:0]       issue_cnt;

  modport master (
    output req_valid, req_x, sq_y,
    input  req_ready, sq_x, resp_valid, resp_y, resp_id, busy, issue_cnt
  );

  modport slave (
    input  req_valid, req_x, sq_y,
    output req_ready, sq_x, resp_valid, resp_y, resp_id, busy, issue_cnt
  );
endinterface

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fsqrt pipeline among NREQ requesters.
// A {valid, id} tag pipe runs alongside the fsqrt so each result is returned, one
// clock after it leaves the pipeline, to the requester that issued it.
//   clk    : clock
//   rstn   : synchronous active-low reset
//   bus_io : fsqrt_arbiter_if slave (request handshake, fsqrt operand/result, response)
module fsqrt_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned IDW  = 2
) (
  input logic            clk,
  input logic            rstn,
  fsqrt_arbiter_if.slave bus_io
);
  localparam int unsigned NPAD = 2 ** IDW;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            grant_any;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  cand;
  logic [IDW:0]    sum;
  logic [NPAD-1:0] valid_pad;
  logic [NPAD-1:0] ready_pad;
  logic [31:0]     x_arr [NPAD];
  logic [31:0]     sq_x;
  tag_t            tag_q [LAT];
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_y_q;
  logic [IDW-1:0]  resp_id_q;
  logic [31:0]     issue_cnt_q, issue_cnt_d;
  logic            busy;

  // Pad requester vectors to 2^IDW so an IDW-bit index is always in range.
  assign valid_pad = NPAD'(bus_io.req_valid);

  for (genvar i = 0; i < NPAD; i++) begin : g_xarr
    if (i < NREQ) begin : g_real
      assign x_arr[i] = bus_io.req_x[32*i +: 32];
    end else begin : g_pad
      assign x_arr[i] = '0;
    end
  end

  // Search ptr, ptr+1, ... modulo NREQ; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    gnt_id    = '0;
    ready_pad = '0;
    sq_x      = '0;
    cand      = '0;
    sum       = '0;
    if (rstn) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        cand = sum[IDW-1:0];
        if (!grant_any && valid_pad[cand]) begin
          grant_any       = 1'b1;
          gnt_id          = cand;
          ready_pad[cand] = 1'b1;
          sq_x            = x_arr[cand];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      // Wrap at NREQ, which may be below 2^IDW.
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
    issue_cnt_d  = issue_cnt_q + 32'(grant_any);
    resp_valid_d = tag_q[LAT-1].vld ? (NREQ'(1) << tag_q[LAT-1].id) : '0;
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned j = 0; j < LAT; j++) busy = busy | tag_q[j].vld;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      resp_id_q    <= '0;
      issue_cnt_q  <= '0;
      for (int unsigned j = 0; j < LAT; j++) tag_q[j] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= bus_io.sq_y;
      resp_id_q    <= tag_q[LAT-1].id;
      issue_cnt_q  <= issue_cnt_d;
      tag_q[0]     <= '{vld: grant_any, id: gnt_id};
      for (int unsigned j = 1; j < LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

  assign bus_io.req_ready  = ready_pad[NREQ-1:0];
  assign bus_io.sq_x       = sq_x;
  assign bus_io.resp_valid = resp_valid_q;
  assign bus_io.resp_y     = resp_y_q;
  assign bus_io.resp_id    = resp_id_q;
  assign bus_io.busy       = busy;
  assign bus_io.issue_cnt  = issue_cnt_q;
endmodule

// File: tb/tb_fsqrt_arbiter.sv
module tb_fsqrt_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fsqrt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  // Exact square roots for the operands used; anything else yields garbage.
  function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
    case (x)
      32'h00000000: return 32'h00000000;
      32'h3E800000: return 32'h3F000000; // 0.25 -> 0.5
      32'h3F800000: return 32'h3F800000; // 1 -> 1
      32'h40100000: return 32'h3FC00000; // 2.25 -> 1.5
      32'h40800000: return 32'h40000000; // 4 -> 2
      32'h41100000: return 32'h40400000; // 9 -> 3
      32'h41800000: return 32'h40800000; // 16 -> 4
      32'h42800000: return 32'h41000000; // 64 -> 8
      32'h43800000: return 32'h41800000; // 256 -> 16
      default:      return x ^ 32'hA5A55A5A;
    endcase
  endfunction

  function automatic logic [31:0] pick(input int i);
    case (i)
      0: return 32'h00000000;
      1: return 32'h3E800000;
      2: return 32'h3F800000;
      3: return 32'h40100000;
      4: return 32'h40800000;
      5: return 32'h41100000;
      6: return 32'h41800000;
      7: return 32'h42800000;
      default: return 32'h43800000;
    endcase
  endfunction

  // Behavioural fsqrt datapath: three unreset register stages.
  logic [31:0] st [LAT];
  always @(posedge clk) begin
    st[0] <= bus.sq_x;
    for (int j = 1; j < LAT; j++) st[j] <= st[j-1];
  end
  assign bus.sq_y = sqrt_ref(st[LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;
  int mptr = 0;
  int mcnt = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic bit model_busy();
    foreach (sb[j]) begin
      if (sb[j].due - cyc >= 1 && sb[j].due - cyc <= LAT) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [32*NREQ-1:0] pack(input logic [31:0] a0, input logic [31:0] a1,
                                              input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // One clock: drive at posedge+1, check and predict at negedge.
  task automatic step(input logic [NREQ-1:0] v, input logic [32*NREQ-1:0] xs, input logic rn);
    logic [NREQ-1:0] exp_rdy;
    int g;
    bus.req_valid = v;
    bus.req_x     = xs;
    rstn          = rn;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (rn) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("issue_cnt", bus.issue_cnt, 32'(mcnt));
    chk("busy", 32'(bus.busy), 32'(model_busy()));
    if (g >= 0) begin
      sb.push_back('{due: cyc + LAT + 1, id: g, y: sqrt_ref(xs[32*g +: 32])});
      mptr = (g + 1) % NREQ;
      mcnt++;
    end
    if (!rn) begin
      #1;
      sb.delete();
      mptr = 0;
      mcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response must match the oldest prediction on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", 32'(bus.resp_valid), 32'(1) << e.id);
        chk("resp_id", 32'(bus.resp_id), 32'(e.id));
        chk("resp_y", bus.resp_y, e.y);
      end else if (bus.resp_valid !== '0) begin
        chk("resp_valid_unexpected", 32'(bus.resp_valid), 32'h0);
      end
    end
  end

  initial begin
    logic [32*NREQ-1:0] xs;
    bus.req_valid = '1;
    bus.req_x     = pack(32'h40800000, 32'h3F800000, 32'h41800000, 32'h42800000);
    rstn          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_y", bus.resp_y, 32'h0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_issue_cnt", bus.issue_cnt, 32'h0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single op: 4.0 on requester 0.
    step(4'b0001, pack(32'h40800000, 0, 0, 0), 1'b1);
    repeat (6) step('0, '0, 1'b1);

    // Grant requester 3 so the pointer returns to 0.
    step(4'b1000, pack(0, 0, 0, 32'h3F800000), 1'b1);

    // Fairness: all four valid for 8 cycles.
    repeat (8) step(4'b1111, pack(32'h3F800000, 32'h41800000, 32'h40800000, 32'h43800000), 1'b1);

    // Pointer wrap: move ptr to 3, then only 3 and 0 valid.
    step(4'b0100, pack(0, 0, 32'h41100000, 0), 1'b1);
    repeat (4) step(4'b1001, pack(32'h40100000, 0, 0, 32'h3E800000), 1'b1);

    // Back-to-back single requester.
    step(4'b0100, pack(0, 0, 32'h3F800000, 0), 1'b1);
    step(4'b0100, pack(0, 0, 32'h40800000, 0), 1'b1);
    step(4'b0100, pack(0, 0, 32'h41800000, 0), 1'b1);
    step(4'b0100, pack(0, 0, 32'h42800000, 0), 1'b1);
    step(4'b0100, pack(0, 0, 32'h43800000, 0), 1'b1);

    // Idle gaps with garbage on the idle lanes.
    for (int i = 0; i < 8; i++) begin
      xs = {$urandom, $urandom, $urandom, $urandom};
      if (i % 2 == 0) step(4'b0010, pack(0, pick(i), 0, 0), 1'b1);
      else            step('0, xs, 1'b1);
    end

    // Reset mid-flight: two issues, then one reset edge while a third is offered.
    step(4'b0010, pack(0, 32'h41100000, 0, 0), 1'b1);
    step(4'b0100, pack(0, 0, 32'h40100000, 0), 1'b1);
    step(4'b1000, pack(0, 0, 0, 32'h3E800000), 1'b0);
    step('0, '0, 1'b1);
    step(4'b0001, pack(32'h42800000, 0, 0, 0), 1'b1);
    repeat (6) step('0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < NREQ; r++) xs[32*r +: 32] = pick($urandom_range(0, 8));
      step(4'($urandom_range(0, 15)), xs, 1'b1);
    end

    // Drain, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) step('0, '0, 1'b1);
    chk("drain_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
